// File: rtl/count_mon_pkg.sv
// Shared types and defaults for the counter step monitor and its classifier.
package count_mon_pkg;

    localparam int DEF_WIDTH  = 3;
    localparam int DEF_WRAP_W = 8;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_e;

    typedef enum logic [1:0] {
        CLS_HOLD = 2'd0,
        CLS_STEP = 2'd1,
        CLS_WRAP = 2'd2,
        CLS_BAD  = 2'd3
    } step_class_e;

endpackage

// File: rtl/count_step_classify.sv
// Classifies one counter transition prev -> cur as hold, +1 step, max->0 wrap, or illegal.
module count_step_classify
    import count_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] cur_i,
    output step_class_e      class_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    // Modulo-2^WIDTH increment: the wrap case falls out of the same compare.
    logic [WIDTH-1:0] prev_inc;
    assign prev_inc = prev_i + WIDTH'(1);

    always_comb begin
        class_o = CLS_BAD;
        if (cur_i == prev_i) begin
            class_o = CLS_HOLD;
        end else if (cur_i == prev_inc) begin
            class_o = (prev_i == MAX_VAL) ? CLS_WRAP : CLS_STEP;
        end
    end

endmodule

// File: rtl/count_step_monitor.sv
// Watches a free-running binary counter: counts wraps and latches the first illegal step.
module count_step_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [WIDTH-1:0]  y_in,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              step_err,
    output logic [WIDTH-1:0]  err_prev,
    output logic [WIDTH-1:0]  err_value,
    output logic [1:0]        state
);

    mon_state_e        state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic              step_err_q, step_err_d;
    logic [WIDTH-1:0]  err_prev_q, err_prev_d;
    logic [WIDTH-1:0]  err_value_q, err_value_d;
    step_class_e       step_class;

    count_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev_i  (prev_q),
        .cur_i   (y_in),
        .class_o (step_class)
    );

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        wrap_pulse_d = 1'b0;
        wrap_count_d = wrap_count_q;
        step_err_d   = step_err_q;
        err_prev_d   = err_prev_q;
        err_value_d  = err_value_q;

        // Clear overrides sampling, so a bad sample coincident with clear is dropped.
        if (clear) begin
            state_d      = ST_SYNC;
            wrap_count_d = '0;
            step_err_d   = 1'b0;
            err_prev_d   = '0;
            err_value_d  = '0;
        end else if (enable) begin
            case (state_q)
                ST_SYNC: begin
                    prev_d  = y_in;
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    case (step_class)
                        CLS_STEP: prev_d = y_in;
                        CLS_WRAP: begin
                            prev_d       = y_in;
                            wrap_pulse_d = 1'b1;
                            if (wrap_count_q != {WRAP_W{1'b1}}) begin
                                wrap_count_d = wrap_count_q + WRAP_W'(1);
                            end
                        end
                        CLS_BAD: begin
                            err_prev_d  = prev_q;
                            err_value_d = y_in;
                            step_err_d  = 1'b1;
                            state_d     = ST_FAULT;
                        end
                        default: ;
                    endcase
                end
                ST_FAULT: ;
                default:  state_d = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            prev_q       <= '0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
            step_err_q   <= 1'b0;
            err_prev_q   <= '0;
            err_value_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_count_q <= wrap_count_d;
            step_err_q   <= step_err_d;
            err_prev_q   <= err_prev_d;
            err_value_q  <= err_value_d;
        end
    end

    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign step_err   = step_err_q;
    assign err_prev   = err_prev_q;
    assign err_value  = err_value_q;
    assign state      = state_q;

endmodule

// File: tb/tb_count_step_monitor.sv
// Scenario bench for count_step_monitor; a second instance with a 2-bit wrap counter covers saturation.
module tb_count_step_monitor;

    logic       clock = 1'b0;
    logic       reset, enable, clear;
    logic [2:0] y_in;

    logic       wrap_pulse, step_err;
    logic [7:0] wrap_count;
    logic [2:0] err_prev, err_value;
    logic [1:0] state;

    logic       sat_pulse, sat_err;
    logic [1:0] sat_count;
    logic [2:0] sat_eprev, sat_evalue;
    logic [1:0] sat_state;

    int errors = 0;
    int checks = 0;

    // Behavioural reference: what the monitor has seen so far, in plain integers.
    int m_state, m_prev, m_cnt, m_cnt_sat, m_err, m_eprev, m_evalue, m_pulse;

    always #5 clock = ~clock;

    count_step_monitor #(.WIDTH(3), .WRAP_W(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .y_in(y_in),
        .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .step_err(step_err),
        .err_prev(err_prev), .err_value(err_value), .state(state)
    );

    count_step_monitor #(.WIDTH(3), .WRAP_W(2)) dut_sat (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .y_in(y_in),
        .wrap_pulse(sat_pulse), .wrap_count(sat_count), .step_err(sat_err),
        .err_prev(sat_eprev), .err_value(sat_evalue), .state(sat_state)
    );

    task automatic cyc(input logic rst, input logic clr, input logic en, input int y);
        reset  = rst;
        clear  = clr;
        enable = en;
        y_in   = 3'(y);
        @(posedge clock);
        m_pulse = 0;
        if (rst) begin
            m_state = 0; m_prev = 0; m_cnt = 0; m_cnt_sat = 0;
            m_err = 0; m_eprev = 0; m_evalue = 0;
        end else if (clr) begin
            m_state = 0; m_cnt = 0; m_cnt_sat = 0;
            m_err = 0; m_eprev = 0; m_evalue = 0;
        end else if (en) begin
            if (m_state == 0) begin
                m_prev = y;
                m_state = 1;
            end else if (m_state == 1) begin
                if (y == m_prev) begin
                    // hold
                end else if (y == (m_prev + 1) % 8) begin
                    if (m_prev == 7) begin
                        m_pulse = 1;
                        if (m_cnt < 255) m_cnt++;
                        if (m_cnt_sat < 3) m_cnt_sat++;
                    end
                    m_prev = y;
                end else begin
                    m_err = 1; m_eprev = m_prev; m_evalue = y; m_state = 2;
                end
            end
        end
        #1;
        $display("t=%0t rst=%0b clr=%0b en=%0b y=%0d -> state=%0d pulse=%0b wraps=%0d err=%0b ep=%0d ev=%0d",
                 $time, rst, clr, en, y, state, wrap_pulse, wrap_count, step_err, err_prev, err_value);
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 5);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%0b exp=0", wrap_pulse); end
        checks++; if (wrap_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", wrap_count); end
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", step_err); end
        checks++; if (err_prev !== 3'd0 || err_value !== 3'd0) begin
            errors++; $display("FAIL reset_errregs got=%0d/%0d exp=0/0", err_prev, err_value);
        end
    endtask

    task automatic test_free_count();
        cyc(0, 0, 1, 0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL free_sync_to_track got=%0d exp=1", state); end
        for (int v = 1; v <= 7; v++) begin
            cyc(0, 0, 1, v);
            checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL free_no_pulse v=%0d got=%0b exp=0", v, wrap_pulse); end
        end
        cyc(0, 0, 1, 0);
        checks++; if (wrap_pulse !== 1'b1) begin errors++; $display("FAIL free_wrap_pulse got=%0b exp=1", wrap_pulse); end
        cyc(0, 0, 1, 1);
        checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL free_pulse_one_cycle got=%0b exp=0", wrap_pulse); end
        checks++; if (wrap_count !== 8'd1) begin errors++; $display("FAIL free_wrap_count got=%0d exp=1", wrap_count); end
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL free_step_err got=%0b exp=0", step_err); end
    endtask

    task automatic test_holds_gaps();
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 3);
        cyc(0, 0, 1, 3);
        cyc(0, 0, 1, 3);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 6);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL gap_state_hold got=%0d exp=1", state); end
        cyc(0, 0, 1, 4);
        cyc(0, 0, 1, 5);
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL gap_no_err got=%0b exp=0", step_err); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL gap_track got=%0d exp=1", state); end
    endtask

    task automatic test_illegal_jump();
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 2);
        cyc(0, 0, 1, 3);
        cyc(0, 0, 1, 5);
        checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL jump_err got=%0b exp=1", step_err); end
        checks++; if (err_prev !== 3'd3) begin errors++; $display("FAIL jump_err_prev got=%0d exp=3", err_prev); end
        checks++; if (err_value !== 3'd5) begin errors++; $display("FAIL jump_err_value got=%0d exp=5", err_value); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL jump_state got=%0d exp=2", state); end
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, int'($urandom_range(0, 7)));
        checks++; if (state !== 2'd2 || err_prev !== 3'd3 || err_value !== 3'd5 || wrap_pulse !== 1'b0) begin
            errors++; $display("FAIL fault_holds got=%0d/%0d/%0d/%0b exp=2/3/5/0", state, err_prev, err_value, wrap_pulse);
        end
    endtask

    task automatic test_clear_from_fault();
        cyc(0, 1, 0, 0);
        checks++; if (state !== 2'd0 || step_err !== 1'b0 || wrap_count !== 8'd0) begin
            errors++; $display("FAIL clear_flags got=%0d/%0b/%0d exp=0/0/0", state, step_err, wrap_count);
        end
        checks++; if (err_prev !== 3'd0 || err_value !== 3'd0) begin
            errors++; $display("FAIL clear_errregs got=%0d/%0d exp=0/0", err_prev, err_value);
        end
        cyc(0, 0, 1, 6);
        cyc(0, 0, 1, 7);
        cyc(0, 0, 1, 0);
        checks++; if (wrap_count !== 8'd1 || wrap_pulse !== 1'b1) begin
            errors++; $display("FAIL clear_fresh_wrap got=%0d/%0b exp=1/1", wrap_count, wrap_pulse);
        end
    endtask

    task automatic test_clear_vs_bad();
        cyc(0, 1, 1, 5);
        checks++; if (step_err !== 1'b0 || state !== 2'd0) begin
            errors++; $display("FAIL clear_beats_bad got=%0b/%0d exp=0/0", step_err, state);
        end
    endtask

    task automatic test_saturation();
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        for (int w = 1; w <= 5; w++) begin
            for (int v = 1; v <= 7; v++) cyc(0, 0, 1, v);
            cyc(0, 0, 1, 0);
            checks++; if (sat_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse wrap=%0d got=%0b exp=1", w, sat_pulse); end
            checks++; if (sat_count !== 2'((w > 3) ? 3 : w)) begin
                errors++; $display("FAIL sat_count wrap=%0d got=%0d exp=%0d", w, sat_count, (w > 3) ? 3 : w);
            end
            checks++; if (wrap_count !== 8'(w)) begin errors++; $display("FAIL wide_count wrap=%0d got=%0d exp=%0d", w, wrap_count, w); end
        end
    endtask

    task automatic test_reset_priority();
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 2);
        cyc(0, 0, 1, 3);
        cyc(1, 1, 1, 6);
        checks++; if (state !== 2'd0 || wrap_pulse !== 1'b0 || wrap_count !== 8'd0 || step_err !== 1'b0) begin
            errors++; $display("FAIL rstprio_outputs got=%0d/%0b/%0d/%0b exp=0/0/0/0", state, wrap_pulse, wrap_count, step_err);
        end
        checks++; if (err_prev !== 3'd0 || err_value !== 3'd0) begin
            errors++; $display("FAIL rstprio_errregs got=%0d/%0d exp=0/0", err_prev, err_value);
        end
        cyc(0, 0, 1, 5);
        cyc(0, 0, 1, 6);
        checks++; if (state !== 2'd1 || step_err !== 1'b0) begin
            errors++; $display("FAIL rstprio_sync_capture got=%0d/%0b exp=1/0", state, step_err);
        end
        cyc(0, 0, 1, 0);
        checks++; if (step_err !== 1'b1 || err_prev !== 3'd6 || err_value !== 3'd0) begin
            errors++; $display("FAIL rstprio_then_bad got=%0b/%0d/%0d exp=1/6/0", step_err, err_prev, err_value);
        end
    endtask

    task automatic test_random();
        int r, y;
        logic en, clr, rst;
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) y = m_prev;
            else if (r < 9) y = (m_prev + 1) % 8;
            else y = int'($urandom_range(0, 7));
            en  = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 99) < 6);
            rst = ($urandom_range(0, 99) < 2);
            cyc(rst, clr, en, y);
            checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state i=%0d got=%0d exp=%0d", i, state, m_state); end
            checks++; if (wrap_pulse !== 1'(m_pulse) || sat_pulse !== 1'(m_pulse)) begin
                errors++; $display("FAIL rnd_pulse i=%0d got=%0b/%0b exp=%0d", i, wrap_pulse, sat_pulse, m_pulse);
            end
            checks++; if (wrap_count !== 8'(m_cnt) || sat_count !== 2'(m_cnt_sat)) begin
                errors++; $display("FAIL rnd_count i=%0d got=%0d/%0d exp=%0d/%0d", i, wrap_count, sat_count, m_cnt, m_cnt_sat);
            end
            checks++; if (step_err !== 1'(m_err) || err_prev !== 3'(m_eprev) || err_value !== 3'(m_evalue)) begin
                errors++; $display("FAIL rnd_err i=%0d got=%0b/%0d/%0d exp=%0d/%0d/%0d",
                                   i, step_err, err_prev, err_value, m_err, m_eprev, m_evalue);
            end
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; enable = 1'b0; y_in = 3'd0;
        m_state = 0; m_prev = 0; m_cnt = 0; m_cnt_sat = 0;
        m_err = 0; m_eprev = 0; m_evalue = 0; m_pulse = 0;
        test_reset();
        test_free_count();
        test_holds_gaps();
        test_illegal_jump();
        test_clear_from_fault();
        test_clear_vs_bad();
        test_saturation();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_step_monitor.md
# count_step_monitor

Checker stage directly downstream of the 3-bit binary counter. It samples the counter output every enabled clock and confirms that each new value is either a hold or a +1 step modulo 2^WIDTH. It counts completed wraps (max → 0) and latches the first illegal transition for debug. Its outputs drive the lab board LEDs and the bench scoreboard.

## Interface
- WIDTH, 3: width of the monitored count.
- WRAP_W, 8: width of the wrap counter.
- clock  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  sample qualifier; when low, all state holds.
- clear  input  1  synchronous soft clear; leaves FAULT and zeroes the counters/flags.
- y_in  input  WIDTH  counter value under observation.
- wrap_pulse  output  1  one-cycle pulse per detected max→0 transition.
- wrap_count  output  WRAP_W  number of wraps; saturates at all-ones.
- step_err  output  1  sticky flag for an illegal transition.
- err_prev  output  WIDTH  last good value before the fault.
- err_value  output  WIDTH  offending value.
- state  output  2  FSM state: SYNC=0, TRACK=1, FAULT=2.

## Operation
- Reset (reset=1 at an edge):
  - state=SYNC.
  - prev register=0.
  - wrap_pulse=0, wrap_count=0, step_err=0, err_prev=0, err_value=0.
- SYNC:
  - On the first enabled cycle, capture y_in into prev.
  - No check is made in this cycle; go to TRACK.
- TRACK, on each enabled cycle, classify y_in against prev:
  - HOLD (y_in==prev): no action.
  - STEP (y_in==prev+1, prev≠max): prev←y_in.
  - WRAP (prev==2^WIDTH−1 and y_in==0): prev←0, wrap_pulse=1 for one cycle, wrap_count+1 unless already all-ones.
  - BAD (anything else): err_prev←prev, err_value←y_in, step_err←1, go to FAULT.
- FAULT:
  - All registers hold and y_in is ignored.
  - wrap_pulse=0.
  - Exit only via clear or reset.
- clear=1 (any state, enable ignored):
  - Next state SYNC.
  - wrap_count, step_err, err_prev, err_value all go to 0; wrap_pulse=0.
- Precedence: reset > clear > enable-qualified FSM action.
- enable=0:
  - No sampling, no state change.
  - wrap_pulse forced to 0.
  - Gaps in enable are not faults; the next enabled sample is compared against the held prev.
- Arithmetic: prev+1 is computed in WIDTH bits, so the wrap is implicit in the compare. The wrap counter never rolls over.

## Timing
- All outputs are registered.
- wrap_pulse, step_err and state reflect the sample taken at edge N from edge N onward, i.e. visible in cycle N+1.
- Latency from an offending y_in to step_err=1 is 1 clock.
- wrap_pulse is high for exactly one cycle per wrap; back-to-back wraps are impossible for WIDTH≥1.
- Reset mid-FAULT or mid-TRACK: all outputs are at reset values after that edge, and the first enabled sample after reset deasserts is a SYNC capture.
- A BAD sample in the same cycle as clear is discarded; clear wins.

## Structure
- Package count_mon_pkg holds:
  - the state enum (SYNC, TRACK, FAULT);
  - the step-class enum (HOLD, STEP, WRAP, BAD);
  - default WIDTH/WRAP_W constants.
- One combinational sub-module, count_step_classify(prev, cur) → class. It is parameterised by WIDTH and reusable for other counter widths.
- The top holds the FSM, the prev register, the saturating wrap counter and the error capture registers.

## Test plan
- Reset then free count: drive 0,1,…,7,0,1 with enable=1 → state goes SYNC→TRACK; one wrap_pulse the cycle after the 7→0 sample; wrap_count=1; step_err=0.
- Holds and enable gaps: 3,3,3, then enable=0 for 4 cycles with y_in=6, then enable=1 with y_in=4 → no error; prev ends at 4.
- Illegal jump: 2,3,5 → step_err=1 one cycle after the 5 is sampled; err_prev=3, err_value=5, state=FAULT; later samples are ignored.
- Clear from FAULT: pulse clear with enable=0 → state=SYNC, all flags and counters 0; a fresh sequence 6,7,0 yields wrap_count=1.
- Saturation: with WRAP_W=2, run 5 full wraps → wrap_count stays at 3 after the third wrap; wrap_pulse still fires on wraps 4 and 5.
- Reset priority: assert reset together with clear and a BAD sample while in TRACK → every output equals its reset value next cycle and state=SYNC.
